pixel_buffer_arb: RTL and testbench

PIXEL_BUFFER_ARB -- requirements
Module: pixel_buffer_arb

---
 rtl/pixel_buffer_arb_pkg.sv | 18 +
 rtl/pixel_buffer_arb_if.sv | 33 +++
 rtl/pixel_buffer_arb_rr_arbiter.sv | 46 ++++
 rtl/pixel_buffer_arb.sv | 122 ++++++++++++
 tb/tb_pixel_buffer_arb.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/pixel_buffer_arb_pkg.sv
// rtl/pixel_buffer_arb_pkg.sv - shared ray-tracer pixel entry type and frame geometry
`ifndef PB_NUM_RAYS
`define PB_NUM_RAYS 16
`endif

package pixel_buffer_arb_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_buffer_entry_t;

  localparam int PB_ENTRY_W = $bits(pixel_buffer_entry_t);
  localparam int PB_MAX_CH  = 8;
  localparam int PB_FRAME_W = 16;

endpackage

// File: rtl/pixel_buffer_arb_if.sv
// rtl/pixel_buffer_arb_if.sv - upstream channel, read and status signals of the pixel buffer
interface pixel_buffer_arb_if
  import pixel_buffer_arb_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int DEPTH  = 200,
  parameter int WIDTH  = PB_ENTRY_W
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [NUM_CH-1:0]            in_valid;
  logic [NUM_CH-1:0][WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]            in_stall;
  logic                         re;
  logic [WIDTH-1:0]             out_data;
  logic                         empty;
  logic                         full;
  logic [CNT_W-1:0]             count;
  logic                         frame_done;
  logic [PB_FRAME_W-1:0]        frame_cnt;

  modport master (
    output in_valid, in_data, re,
    input  in_stall, out_data, empty, full, count, frame_done, frame_cnt
  );

  modport slave (
    input  in_valid, in_data, re,
    output in_stall, out_data, empty, full, count, frame_done, frame_cnt
  );

endinterface

// File: rtl/pixel_buffer_arb_rr_arbiter.sv
// rtl/pixel_buffer_arb_rr_arbiter.sv - round-robin arbiter owning the priority pointer
module rr_arbiter #(
  parameter int NUM_CH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              en,
  output logic [NUM_CH-1:0] grant
);

  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] next_ptr;
  logic [PW:0]   sum;
  logic          found;

  // Scan from ptr with wrap; the first requester found wins.
  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    sum      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_CH)) begin
        sum = sum - (PW+1)'(NUM_CH);
      end
      if (en && !found && req[sum[PW-1:0]]) begin
        grant[sum[PW-1:0]] = 1'b1;
        found              = 1'b1;
        next_ptr           = (sum == (PW+1)'(NUM_CH - 1)) ? '0 : sum[PW-1:0] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= next_ptr;
    end
  end

endmodule

// File: rtl/pixel_buffer_arb.sv
// rtl/pixel_buffer_arb.sv - arbitrated FWFT pixel buffer with optional frame counting (PB_FRAME_COUNT_EN)
module pixel_buffer_arb
  import pixel_buffer_arb_pkg::*;
#(
  parameter int NUM_CH   = 3,
  parameter int DEPTH    = 200,
  parameter int WIDTH    = $bits(pixel_buffer_entry_t),
  parameter int NUM_RAYS = `PB_NUM_RAYS
) (
  input logic               clk,
  input logic               rst,
  pixel_buffer_arb_if.slave bus
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]     head;
  logic [AW-1:0]     tail;
  logic [CNT_W-1:0]  count;
  logic [NUM_CH-1:0] grant;
  logic [WIDTH-1:0]  wr_data;
  logic              full;
  logic              empty;
  logic              wr_en;
  logic              rd_en;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign wr_en = |grant;
  assign rd_en = bus.re & ~empty & ~rst;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (bus.in_valid),
    .en    (~full & ~rst),
    .grant (grant)
  );

  // Grant is one-hot, so an OR of the masked channels is the selected entry.
  always_comb begin
    wr_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant[c]) begin
        wr_data = wr_data | bus.in_data[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[tail] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_en) begin
        tail <= ptr_inc(tail);
      end
      if (rd_en) begin
        head <= ptr_inc(head);
      end
      if (wr_en && !rd_en) begin
        count <= count + 1'b1;
      end else if (!wr_en && rd_en) begin
        count <= count - 1'b1;
      end
    end
  end

  assign bus.in_stall = rst ? '1 : (bus.in_valid & ~grant);
  assign bus.out_data = mem[head];
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.count    = count;

`ifdef PB_FRAME_COUNT_EN
  localparam int RC_W = (NUM_RAYS > 1) ? $clog2(NUM_RAYS) : 1;

  logic [RC_W-1:0]       rd_cnt;
  logic                  frame_done_q;
  logic [PB_FRAME_W-1:0] frame_cnt_q;

  // rd_cnt holds reads modulo NUM_RAYS; the wrapping read raises frame_done for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt       <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (rd_en) begin
        if (rd_cnt == RC_W'(NUM_RAYS - 1)) begin
          rd_cnt       <= '0;
          frame_done_q <= 1'b1;
          frame_cnt_q  <= frame_cnt_q + 1'b1;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.frame_done = frame_done_q;
  assign bus.frame_cnt  = frame_cnt_q;
`else
  assign bus.frame_done = 1'b0;
  assign bus.frame_cnt  = '0;
`endif

endmodule

// File: tb/tb_pixel_buffer_arb.sv
// tb/tb_pixel_buffer_arb.sv - scoreboard bench for pixel_buffer_arb (NUM_CH=3, DEPTH=4, NUM_RAYS=5)
module tb_pixel_buffer_arb;

  localparam int NCH = 3;
  localparam int DEP = 4;
  localparam int W   = 24;
  localparam int NR  = 5;
`ifdef PB_FRAME_COUNT_EN
  localparam logic [15:0] EXP_FC = 16'd2;
`else
  localparam logic [15:0] EXP_FC = 16'd0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pixel_buffer_arb_if #(.NUM_CH(NCH), .DEPTH(DEP), .WIDTH(W)) bus ();

  pixel_buffer_arb #(.NUM_CH(NCH), .DEPTH(DEP), .WIDTH(W), .NUM_RAYS(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int             checks = 0;
  int             errors = 0;
  logic [W-1:0]   exp_q[$];
  int             rd_seen = 0;
  logic           exp_fd = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic r,
                       input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    bus.in_valid   = v;
    bus.re         = r;
    bus.in_data[0] = W'(d0);
    bus.in_data[1] = W'(d1);
    bus.in_data[2] = W'(d2);
  endtask

  // One cycle: drive, check stall mid-cycle, queue whichever entry is expected to be granted.
  task automatic step(input logic [2:0] v, input logic r, input logic [2:0] exp_stall,
                      input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    logic [7:0] d [3];
    d[0] = d0; d[1] = d1; d[2] = d2;
    drive(v, r, d0, d1, d2);
    @(negedge clk);
    check("in_stall", 32'(bus.in_stall), 32'(exp_stall));
    for (int c = 0; c < NCH; c++) begin
      if (v[c] && !exp_stall[c]) exp_q.push_back(W'(d[c]));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(3'b000, 1'b0, 8'h0, 8'h0, 8'h0);
    exp_q.delete();
    @(negedge clk);
    check("stall_in_reset", 32'(bus.in_stall), 32'h7);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_count", 32'(bus.count), 32'h0);
    check("rst_empty", 32'(bus.empty), 32'h1);
    check("rst_full", 32'(bus.full), 32'h0);
    check("rst_frame_done", 32'(bus.frame_done), 32'h0);
    check("rst_frame_cnt", 32'(bus.frame_cnt), 32'h0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      rd_seen = 0;
      exp_fd  = 1'b0;
    end else begin
      check("frame_done", 32'(bus.frame_done), 32'(exp_fd));
      exp_fd = 1'b0;
      if (bus.re && !bus.empty) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_data: got %0h expected no entry at %0t", bus.out_data, $time);
        end else begin
          check("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
        end
        rd_seen++;
`ifdef PB_FRAME_COUNT_EN
        if (rd_seen % NR == 0) exp_fd = 1'b1;
`endif
      end
    end
  end

  initial begin
    logic [2:0] rr_stall [3];
    rr_stall[0] = 3'b110;
    rr_stall[1] = 3'b101;
    rr_stall[2] = 3'b011;

    do_reset();

    // All channels valid with reads: grants rotate 0,1,2,0,1,2.
    for (int k = 0; k < 6; k++) begin
      step(3'b111, 1'b1, rr_stall[k % 3], 8'(8'h10 + k), 8'(8'h20 + k), 8'(8'h30 + k));
    end
    step(3'b000, 1'b1, 3'b000, 8'h0, 8'h0, 8'h0);
    check("rr_drained_empty", 32'(bus.empty), 32'h1);

    // Channel 1 fills the 4-deep buffer, then one read frees a slot for 0xE.
    do_reset();
    step(3'b010, 1'b0, 3'b000, 8'h0, 8'hA, 8'h0);
    step(3'b010, 1'b0, 3'b000, 8'h0, 8'hB, 8'h0);
    step(3'b010, 1'b0, 3'b000, 8'h0, 8'hC, 8'h0);
    step(3'b010, 1'b0, 3'b000, 8'h0, 8'hD, 8'h0);
    check("fill_full", 32'(bus.full), 32'h1);
    check("fill_count", 32'(bus.count), 32'h4);
    step(3'b010, 1'b0, 3'b010, 8'h0, 8'hE, 8'h0);
    step(3'b010, 1'b1, 3'b010, 8'h0, 8'hE, 8'h0);
    check("after_read_count", 32'(bus.count), 32'h3);
    step(3'b010, 1'b0, 3'b000, 8'h0, 8'hE, 8'h0);
    check("refill_count", 32'(bus.count), 32'h4);
    for (int k = 0; k < 4; k++) step(3'b000, 1'b1, 3'b000, 8'h0, 8'h0, 8'h0);
    check("fill_drained_empty", 32'(bus.empty), 32'h1);

    // Reads on an empty buffer change nothing.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(3'b000, 1'b1, 3'b000, 8'h0, 8'h0, 8'h0);
      check("empty_re_count", 32'(bus.count), 32'h0);
      check("empty_re_empty", 32'(bus.empty), 32'h1);
    end

    // Twelve entries streamed through: frames complete after reads 5 and 10.
    for (int k = 0; k < 12; k++) begin
      step(3'b001, 1'b1, 3'b000, 8'(8'h40 + k), 8'h0, 8'h0);
    end
    step(3'b000, 1'b1, 3'b000, 8'h0, 8'h0, 8'h0);
    step(3'b000, 1'b0, 3'b000, 8'h0, 8'h0, 8'h0);
    check("frame_cnt", 32'(bus.frame_cnt), 32'(EXP_FC));
    check("frame_empty", 32'(bus.empty), 32'h1);

    // Reset mid-frame with count=3 and four reads done.
    do_reset();
    for (int k = 0; k < 5; k++) step(3'b100, 1'b1, 3'b000, 8'h0, 8'h0, 8'(8'h50 + k));
    for (int k = 5; k < 7; k++) step(3'b100, 1'b0, 3'b000, 8'h0, 8'h0, 8'(8'h50 + k));
    rst = 1'b1;
    drive(3'b111, 1'b0, 8'h60, 8'h61, 8'h62);
    @(negedge clk);
    check("pre_rst_count", 32'(bus.count), 32'h3);
    check("mid_rst_stall", 32'(bus.in_stall), 32'h7);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("post_rst_count", 32'(bus.count), 32'h0);
    check("post_rst_empty", 32'(bus.empty), 32'h1);
    step(3'b111, 1'b0, 3'b110, 8'h60, 8'h61, 8'h62);
    check("first_write_count", 32'(bus.count), 32'h1);
    step(3'b000, 1'b1, 3'b000, 8'h0, 8'h0, 8'h0);
    step(3'b000, 1'b1, 3'b000, 8'h0, 8'h0, 8'h0);
    step(3'b000, 1'b0, 3'b000, 8'h0, 8'h0, 8'h0);
    check("end_empty", 32'(bus.empty), 32'h1);
    check("end_queue", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
